// File: rtl/alu_rr_scheduler.sv
// -----------------------------------------------------------------------------
// alu_rr_scheduler
//   Shares one external 4-bit add/sub/XOR ALU between two requesters.
//   A round-robin arbiter grants one request in IDLE. The winner's operands are
//   latched, the ALU is driven for one EXEC cycle, and the sampled result is
//   returned on a single response channel tagged with the requester id.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req{0,1}_valid/_ready    request handshake per requester
//   req{0,1}_x/_y/_op        4-bit operands and 2-bit opcode per requester
//   resp_valid/_ready        response handshake
//   resp_id, resp_data       id of the issuing requester and 4-bit result
//   alu_x, alu_y             operands to the ALU (held in registers)
//   alu_f0, alu_f1           ALU function selects (op[0], op[1])
//   alu_out                  combinational ALU result
//   busy                     high whenever the FSM is not in IDLE
//   op_count                 completed-response counter (wraps)
// -----------------------------------------------------------------------------
module alu_rr_scheduler #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_x,
  input  logic [3:0]       req0_y,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_x,
  input  logic [3:0]       req1_y,
  input  logic [1:0]       req1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [3:0]       resp_data,
  output logic [3:0]       alu_x,
  output logic [3:0]       alu_y,
  output logic             alu_f0,
  output logic             alu_f1,
  input  logic [3:0]       alu_out,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_last_grant;
  logic [3:0]       r_x;
  logic [3:0]       r_y;
  logic [1:0]       r_op;
  logic             r_id;
  logic [3:0]       r_resp_data;
  logic             r_resp_id;
  logic [CNT_W-1:0] r_op_count;

  logic             w_accept;
  logic             w_winner;
  logic             w_resp_hs;

  // Next-state logic, arbitration and handshake outputs.
  // All handshake outputs are forced low while rst is high so nothing is
  // accepted or reported during the reset cycle.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_winner     = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    resp_valid   = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        // With both valid, the requester that did not win last time wins.
        if (req0_valid && req1_valid) begin
          w_winner = ~r_last_grant;
        end else begin
          w_winner = req1_valid;
        end
        if (!rst && (req0_valid || req1_valid)) begin
          w_accept     = 1'b1;
          req0_ready   = ~w_winner;
          req1_ready   = w_winner;
          w_next_state = S_EXEC;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_EXEC: begin
        busy         = ~rst;
        w_next_state = S_RESP;
      end
      S_RESP: begin
        busy       = ~rst;
        resp_valid = ~rst;
        if (resp_ready) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_RESP;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign w_resp_hs = resp_valid & resp_ready;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Operand latch, result capture, arbitration history and completion counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_x          <= 4'h0;
      r_y          <= 4'h0;
      r_op         <= 2'b00;
      r_id         <= 1'b0;
      r_resp_data  <= 4'h0;
      r_resp_id    <= 1'b0;
      r_op_count   <= {CNT_W{1'b0}};
    end else begin
      if (w_accept) begin
        r_last_grant <= w_winner;
        r_id         <= w_winner;
        r_x          <= w_winner ? req1_x  : req0_x;
        r_y          <= w_winner ? req1_y  : req0_y;
        r_op         <= w_winner ? req1_op : req0_op;
      end
      if (r_state == S_EXEC) begin
        r_resp_data <= alu_out;
        r_resp_id   <= r_id;
      end
      if (w_resp_hs) begin
        r_op_count <= r_op_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign alu_x     = r_x;
  assign alu_y     = r_y;
  assign alu_f0    = r_op[0];
  assign alu_f1    = r_op[1];
  assign resp_data = r_resp_data;
  assign resp_id   = r_resp_id;
  assign op_count  = r_op_count;

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one four-bit add/sub/XOR ALU between two requesters.
- Arbitrates between them round-robin, latches the operands and drives the ALU function selects.
- Captures the ALU result and returns it on a single response channel tagged with the requester ID.
- Sits in the parent wrapper between the pin-level request logic and the ALU instance.

Parameters:
CNT_W, 8, width of the completed-operation counter (wraps modulo 2^CNT_W)

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_x  input  4  requester 0 operand X
req0_y  input  4  requester 0 operand Y
req0_op  input  2  requester 0 opcode
req1_valid  input  1  requester 1 has an operation
req1_ready  output  1  requester 1 operation accepted this cycle
req1_x  input  4  requester 1 operand X
req1_y  input  4  requester 1 operand Y
req1_op  input  2  requester 1 opcode
resp_valid  output  1  result available
resp_ready  input  1  consumer takes result
resp_id  output  1  requester that issued the result
resp_data  output  4  result
alu_x  output  4  to ALU X3..X0
alu_y  output  4  to ALU Y3..Y0
alu_f0  output  1  to ALU F0 (sub / invert-Y)
alu_f1  output  1  to ALU F1 (0 = sum path, 1 = XOR path)
alu_out  input  4  from ALU OUT3..OUT0, combinational from alu_* outputs
busy  output  1  high in any state other than IDLE
op_count  output  CNT_W  completed responses

Behaviour:
- Opcode to ALU select mapping: alu_f1 = op[1], alu_f0 = op[0].
  - 00: X+Y mod 16.
  - 01: X-Y mod 16 (X + ~Y + 1).
  - 10: X^Y.
  - 11: ~(X^Y).
- FSM states:
  - IDLE: a grant is issued when any reqN_valid is high.
    - Winner: if exactly one requester is valid, it wins. If both are valid, the requester not equal to last_grant wins.
    - reqN_ready is high for the winner only, combinationally from the valids, and only in IDLE.
    - On the handshake: latch x, y, op and id into operand registers, set last_grant = winner, go to EXEC.
  - EXEC: exactly one cycle. The alu_* outputs are driven from the operand registers; alu_out is sampled at the clock edge into resp_data. Go to RESP.
  - RESP: resp_valid = 1, and resp_id and resp_data are held stable. The state is held while resp_ready = 0. On resp_valid && resp_ready: op_count increments (wrapping), then go to IDLE.
- The alu_* outputs always reflect the operand registers and are stable outside the latch edge.
- Both reqN_ready outputs are 0 in EXEC and RESP.
- Latency: handshake in cycle N gives resp_valid in cycle N+2.
  - With resp_ready tied high, peak throughput is one operation per 3 cycles.
  - No new grant is made in the same cycle as the response handshake.
- Fairness: under continuous dual requests, grants alternate 0,1,0,1.
- Requester obligations: a requester holds valid and operands until ready. The block does not check this.
- Reset (any state, including mid-EXEC or mid-RESP):
  - state = IDLE, last_grant = 1 (so requester 0 wins the first contention).
  - Operand registers, resp_data, resp_id and op_count = 0.
  - resp_valid = 0, busy = 0, both ready = 0 during the reset cycle.
  - Any in-flight result is discarded and not counted.
- Requests presented during reset are not accepted. They are arbitrated in the first cycle after rst falls.

Test Plan:
- After reset, req0 only with x=5, y=3, op=00, resp_ready=1 -> req0_ready in cycle N; resp_valid in N+2 with resp_id=0, resp_data=8; op_count=1.
- Four single-requester ops:
  - req1 x=3, y=5, op=01 -> resp_data=0xE, resp_id=1.
  - x=0xA, y=0x6, op=10 -> 0xC.
  - same operands, op=11 -> 0x3.
  - x=0xF, y=0x1, op=00 -> 0x0 (wrap).
- Both requesters valid continuously from the first cycle after reset, six ops -> resp_id sequence 0,1,0,1,0,1; no grant gap beyond 3 cycles.
- Backpressure: hold resp_ready=0 for 4 cycles in RESP -> resp_valid, resp_id and resp_data are stable. Both reqN_ready stay 0 and op_count is unchanged until resp_ready rises.
- Assert rst during EXEC of a req0 op -> next cycle state IDLE, resp_valid=0, op_count=0. A pending req1 is then granted first and its result is correct.
- Set op_count to 2^CNT_W-1 by issuing 255 ops (CNT_W=8), then one more -> op_count wraps to 0.
